ex_muldiv_unit: RTL

//  Execute-stage iterative multiply/divide unit fed directly by the ID/EX pipeline register outputs.

---
 rtl/ex_muldiv_unit_if.sv | 17 +
 rtl/ex_muldiv_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: request/result bundle between the ID/EX register outputs and the multiply/divide unit
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             stall;

    modport master (output start, op, a, b, flush, input hi, lo, busy, done, div_zero, stall);
    modport slave  (input start, op, a, b, flush, output hi, lo, busy, done, div_zero, stall);
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 signed/unsigned multiply and restoring divide with pipeline stall
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_clrn,
    ex_muldiv_unit_if.slave      bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             r_state, w_next;
    logic               r_div, r_sa, r_neg, r_dzp, r_done, r_dz;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_m, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_accept, w_dz_req, w_sa, w_sb, w_write;
    logic [WIDTH-1:0]   w_ma, w_mb, w_rem, w_quo, w_hi, w_lo;
    logic [WIDTH:0]     w_mul_sum, w_diff;
    logic [2*WIDTH:0]   w_shift;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;

    assign w_accept = bus.start & ~bus.flush & (r_state == S_IDLE);
    assign w_sa     = bus.op[0] & bus.a[WIDTH-1];
    assign w_sb     = bus.op[0] & bus.b[WIDTH-1];
    assign w_ma     = w_sa ? -bus.a : bus.a;
    assign w_mb     = w_sb ? -bus.b : bus.b;
    assign w_dz_req = bus.op[1] & (bus.b == '0);
    assign w_write  = (r_state == S_FIN) & ~bus.flush;

    // Multiply step: conditionally add the multiplicand to the upper half, then shift the whole accumulator right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: shift {rem,quot} left, trial-subtract the divisor, keep the difference only if non-negative.
    assign w_shift    = {r_acc, 1'b0};
    assign w_diff     = w_shift[2*WIDTH:WIDTH] - {1'b0, r_m};
    assign w_div_next = w_diff[WIDTH] ? w_shift[2*WIDTH-1:0] : {w_diff[WIDTH-1:0], w_shift[WIDTH-1:1], 1'b1};

    // Sign fix-up applied only when results are committed; the divide-by-zero pattern bypasses it.
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_rem  = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_quo  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_hi   = r_dzp ? r_acc[2*WIDTH-1:WIDTH] : r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo   = r_dzp ? r_acc[WIDTH-1:0] : r_div ? w_quo : w_prod[WIDTH-1:0];

    // State register.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next state: divide-by-zero skips the iterations; flush always returns to idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_dz_req ? S_FIN : S_RUN) : S_IDLE;
            S_RUN:   w_next = bus.flush ? S_IDLE : (r_cnt == CW'(1) ? S_FIN : S_RUN);
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration and result commit.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_div  <= 1'b0;
            r_sa   <= 1'b0;
            r_neg  <= 1'b0;
            r_dzp  <= 1'b0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_cnt  <= '0;
            r_m    <= '0;
            r_acc  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_div <= bus.op[1];
                r_sa  <= w_sa;
                r_neg <= w_sa ^ w_sb;
                r_dzp <= w_dz_req;
                r_dz  <= 1'b0;
                r_cnt <= CW'(WIDTH);
                r_m   <= bus.op[1] ? w_mb : w_ma;
                r_acc <= w_dz_req ? {bus.a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, bus.op[1] ? w_ma : w_mb};
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CW'(1);
                r_acc <= r_div ? w_div_next : w_mul_next;
            end else if (w_write) begin
                r_hi   <= w_hi;
                r_lo   <= w_lo;
                r_done <= 1'b1;
                r_dz   <= r_dzp;
            end
        end
    end

    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = r_done;
    assign bus.div_zero = r_dz;
    assign bus.stall    = (bus.start & (r_state == S_IDLE) & ~bus.flush) | (r_state == S_RUN);
endmodule
